// File: rtl/spr_bus_master_if.sv
// ----------------------------------------------------------------------------
// spr_bus_master_if
//   Bundles the command/response handshake and the SPR bus used by
//   spr_bus_master.
//
//   Command side : cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_addr_i, cmd_dat_i
//   Response side: rsp_valid_o, rsp_dat_o, rsp_err_o
//   SPR bus      : spr_bus_addr_o, spr_bus_we_o, spr_bus_stb_o,
//                  spr_bus_dat_o, spr_bus_dat_i, spr_bus_ack_i
//
//   Signal suffixes are given from the master's point of view.
//   modport master : used by spr_bus_master
//   modport slave  : used by the agent that issues commands and models the
//                    SPR slave
// ----------------------------------------------------------------------------
interface spr_bus_master_if #(
  parameter int W = 32
);
  // command
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [15:0]   cmd_addr_i;
  logic [W-1:0]  cmd_dat_i;
  // response
  logic          rsp_valid_o;
  logic [W-1:0]  rsp_dat_o;
  logic          rsp_err_o;
  // SPR bus
  logic [15:0]   spr_bus_addr_o;
  logic          spr_bus_we_o;
  logic          spr_bus_stb_o;
  logic [W-1:0]  spr_bus_dat_o;
  logic [W-1:0]  spr_bus_dat_i;
  logic          spr_bus_ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_dat_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    output spr_bus_addr_o, spr_bus_we_o, spr_bus_stb_o, spr_bus_dat_o,
    input  spr_bus_dat_i, spr_bus_ack_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_dat_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  spr_bus_addr_o, spr_bus_we_o, spr_bus_stb_o, spr_bus_dat_o,
    output spr_bus_dat_i, spr_bus_ack_i
  );
endinterface

// File: rtl/spr_bus_master.sv
// ----------------------------------------------------------------------------
// spr_bus_master
//   Turns single mtspr/mfspr commands into strobe/ack transactions on the SPR
//   bus, with a bounded wait for the slave's acknowledge.
//
//   Parameters
//     OPTION_OPERAND_WIDTH : SPR data width
//     TIMEOUT_CYCLES       : maximum strobe-high cycles without ack (2..256)
//
//   Ports
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : spr_bus_master_if.master (command, response and SPR bus signals)
//
//   Behaviour
//     IDLE : cmd_ready_o=1; an accepted command is latched, REQ follows.
//     REQ  : strobe high with the latched addr/we/data. An ack completes the
//            transaction (read data captured for reads, 0 for writes). With
//            no ack, the strobe stays up exactly TIMEOUT_CYCLES cycles and
//            the transaction completes with rsp_err_o=1.
//     RSP  : one-cycle rsp_valid_o pulse, then back to IDLE. RSP plus IDLE
//            guarantee two strobe-low cycles between transactions.
// ----------------------------------------------------------------------------
module spr_bus_master #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  spr_bus_master_if.master      bus
);

  localparam int W     = OPTION_OPERAND_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  // state and datapath registers
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [15:0]       r_addr;
  logic [W-1:0]      r_dat;
  logic [W-1:0]      r_rsp_dat;
  logic              r_rsp_err;

  // next-state values
  state_t            w_state_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_cmd_latch;
  logic [W-1:0]      w_rsp_dat_next;
  logic              w_rsp_err_next;

  // decoded outputs
  logic              w_in_idle;
  logic              w_in_req;
  logic              w_in_rsp;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_dat     <= '0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rsp_dat <= w_rsp_dat_next;
      r_rsp_err <= w_rsp_err_next;
      if (w_cmd_latch) begin
        r_we   <= bus.cmd_we_i;
        r_addr <= bus.cmd_addr_i;
        r_dat  <= bus.cmd_dat_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_cmd_latch    = 1'b0;
    w_rsp_dat_next = r_rsp_dat;
    w_rsp_err_next = r_rsp_err;

    case (r_state)
      S_IDLE: begin
        // cmd_ready_o is high throughout IDLE outside reset, and the reset
        // branch of the state register overrides anything computed here.
        if (bus.cmd_valid_i) begin
          w_cmd_latch  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = S_REQ;
        end
      end

      S_REQ: begin
        // Ack is checked first so an ack in the final timeout cycle still
        // completes normally.
        if (bus.spr_bus_ack_i) begin
          w_rsp_dat_next = r_we ? '0 : bus.spr_bus_dat_i;
          w_rsp_err_next = 1'b0;
          w_state_next   = S_RSP;
        end else if (r_cnt == CNT_LAST) begin
          w_rsp_dat_next = '0;
          w_rsp_err_next = 1'b1;
          w_state_next   = S_RSP;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_RSP: begin
        w_rsp_dat_next = '0;
        w_rsp_err_next = 1'b0;
        w_state_next   = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  //   Everything is forced low while rst is high, so the strobe is already
  //   down by the reset edge and a command is never accepted during reset.
  // --------------------------------------------------------------------------
  assign w_in_idle = !rst && (r_state == S_IDLE);
  assign w_in_req  = !rst && (r_state == S_REQ);
  assign w_in_rsp  = !rst && (r_state == S_RSP);

  assign bus.cmd_ready_o    = w_in_idle;
  assign bus.spr_bus_stb_o  = w_in_req;
  assign bus.spr_bus_we_o   = rst ? 1'b0 : r_we;
  assign bus.spr_bus_addr_o = rst ? '0   : r_addr;
  assign bus.spr_bus_dat_o  = rst ? '0   : r_dat;

  // Response fields are only meaningful in the RSP pulse and read as 0
  // otherwise.
  assign bus.rsp_valid_o = w_in_rsp;
  assign bus.rsp_dat_o   = w_in_rsp ? r_rsp_dat : '0;
  assign bus.rsp_err_o   = w_in_rsp ? r_rsp_err : 1'b0;

endmodule
